// File: rtl/wb_split_pkg.sv
// Shared constants for the Wishbone 1-to-N splitter.
// FSM state encodings and default slot/timeout geometry.
package wb_split_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef logic [1:0] wb_state_t;

    localparam int DEF_NUM_SLAVES = 27;
    localparam int DEF_SLOT_LSB   = 16;
    localparam int DEF_SLOT_BITS  = 5;
    localparam int DEF_TIMEOUT    = 255;

    function automatic int tmo_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_split_tmo_cnt.sv
// Watchdog counter for the splitter: clear on accept, count idle
// ACTIVE cycles, flag expiry at TIMEOUT_CYCLES-1.
import wb_split_pkg::*;

module wb_split_tmo_cnt #(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_split_tmo.sv
// Wishbone B4-classic 1-to-N splitter with unmapped-slot error and an
// optional per-transaction watchdog (enable with WB_SPLIT_TIMEOUT_EN).
import wb_split_pkg::*;

module wb_split_tmo #(
    parameter int NUM_SLAVES       = DEF_NUM_SLAVES,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SEL_WIDTH        = DATA_WIDTH / 8,
    parameter int ADDR_SEL_LOW_BIT = DEF_SLOT_LSB,
    parameter int SLOT_BITS        = DEF_SLOT_BITS,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             m_wb_cyc_i,
    input  logic                             m_wb_stb_i,
    input  logic                             m_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]            m_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]            m_wb_dat_i,
    input  logic [SEL_WIDTH-1:0]             m_wb_sel_i,
    output logic [DATA_WIDTH-1:0]            m_wb_dat_o,
    output logic                             m_wb_ack_o,
    output logic                             m_wb_err_o,
    output logic [NUM_SLAVES-1:0]            s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]            s_wb_stb_o,
    output logic [NUM_SLAVES-1:0]            s_wb_we_o,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_wb_adr_o,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wb_dat_o,
    output logic [NUM_SLAVES*SEL_WIDTH-1:0]  s_wb_sel_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic [NUM_SLAVES-1:0]            s_wb_ack_i,
    input  logic [NUM_SLAVES-1:0]            s_wb_err_i
`ifdef WB_SPLIT_TIMEOUT_EN
    ,
    output logic                             tmo_flag_o
`endif
);

    if (TIMEOUT_CYCLES < 1 || NUM_SLAVES < 1 ||
        NUM_SLAVES > (1 << SLOT_BITS)) begin : g_param_err
        $error("wb_split_tmo: illegal parameter combination");
    end

    wb_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [SLOT_BITS-1:0]  slot_q, slot_d;
    logic [NUM_SLAVES-1:0] stb_q, stb_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;

    logic [SLOT_BITS-1:0]  req_slot;
    logic                  req_mapped;
    logic                  req_valid;
    logic [NUM_SLAVES-1:0] req_hot;
    logic                  rsp_ack;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_dat;

`ifdef WB_SPLIT_TIMEOUT_EN
    logic cnt_clr;
    logic cnt_en;
    logic cnt_exp;
    logic tmo_q, tmo_d;
`endif

    assign req_slot   = m_wb_adr_i[ADDR_SEL_LOW_BIT +: SLOT_BITS];
    assign req_mapped = int'({1'b0, req_slot}) < NUM_SLAVES;
    assign req_valid  = m_wb_cyc_i & m_wb_stb_i;

    // Slot decode for the new request and response mux for the latched slot.
    always_comb begin
        req_hot = '0;
        rsp_ack = 1'b0;
        rsp_err = 1'b0;
        rsp_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (req_slot == SLOT_BITS'(i)) begin
                req_hot[i] = 1'b1;
            end
            if (slot_q == SLOT_BITS'(i)) begin
                rsp_ack = s_wb_ack_i[i];
                rsp_err = s_wb_err_i[i];
                rsp_dat = s_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        slot_d  = slot_q;
        stb_d   = stb_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = rdat_q;
`ifdef WB_SPLIT_TIMEOUT_EN
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    adr_d  = m_wb_adr_i;
                    wdat_d = m_wb_dat_i;
                    sel_d  = m_wb_sel_i;
                    we_d   = m_wb_we_i;
                    slot_d = req_slot;
                    if (req_mapped) begin
                        state_d = ST_ACTIVE;
                        stb_d   = req_hot;
`ifdef WB_SPLIT_TIMEOUT_EN
                        cnt_clr = 1'b1;
`endif
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdat_d  = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                // Abort takes priority: the slave never saw a gated strobe.
                if (!m_wb_cyc_i) begin
                    state_d = ST_IDLE;
                    stb_d   = '0;
                end else if (rsp_ack) begin
                    state_d = ST_RESP;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    rdat_d  = rsp_dat;
                end else if (rsp_err) begin
                    state_d = ST_RESP;
                    stb_d   = '0;
                    err_d   = 1'b1;
                    rdat_d  = '0;
                end
`ifdef WB_SPLIT_TIMEOUT_EN
                else if (cnt_exp) begin
                    state_d = ST_RESP;
                    stb_d   = '0;
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                stb_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            slot_q  <= '0;
            stb_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            slot_q  <= slot_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

`ifdef WB_SPLIT_TIMEOUT_EN
    wb_split_tmo_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cnt (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .expire_o (cnt_exp)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_flag_o = tmo_q;
`endif

    assign s_wb_cyc_o = stb_q & {NUM_SLAVES{m_wb_cyc_i}};
    assign s_wb_stb_o = stb_q & {NUM_SLAVES{m_wb_cyc_i}};
    assign s_wb_we_o  = stb_q & {NUM_SLAVES{m_wb_cyc_i & we_q}};
    assign s_wb_adr_o = {NUM_SLAVES{adr_q}};
    assign s_wb_dat_o = {NUM_SLAVES{wdat_q}};
    assign s_wb_sel_o = {NUM_SLAVES{sel_q}};

    assign m_wb_dat_o = rdat_q;
    assign m_wb_ack_o = ack_q;
    assign m_wb_err_o = err_q;

endmodule

// File: tb/tb_wb_split_tmo.sv
// Scoreboard bench for wb_split_tmo (TIMEOUT_CYCLES=8); directed
// transactions push expected responses, a monitor checks them.
module tb_wb_split_tmo;

    localparam int N   = 27;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    logic            clk;
    logic            rst;
    logic            m_cyc, m_stb, m_we;
    logic [AW-1:0]   m_adr;
    logic [DW-1:0]   m_wdat;
    logic [SW-1:0]   m_sel;
    logic [DW-1:0]   m_dat;
    logic            m_ack, m_err;
    logic [N-1:0]    s_cyc, s_stb, s_we;
    logic [N*AW-1:0] s_adr;
    logic [N*DW-1:0] s_dout;
    logic [N*SW-1:0] s_sel;
    logic [N*DW-1:0] s_dat;
    logic [N-1:0]    s_ack, s_err;
`ifdef WB_SPLIT_TIMEOUT_EN
    logic            tmo;
`endif

    typedef struct {
        bit          err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    wb_split_tmo #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .m_wb_cyc_i (m_cyc),
        .m_wb_stb_i (m_stb),
        .m_wb_we_i  (m_we),
        .m_wb_adr_i (m_adr),
        .m_wb_dat_i (m_wdat),
        .m_wb_sel_i (m_sel),
        .m_wb_dat_o (m_dat),
        .m_wb_ack_o (m_ack),
        .m_wb_err_o (m_err),
        .s_wb_cyc_o (s_cyc),
        .s_wb_stb_o (s_stb),
        .s_wb_we_o  (s_we),
        .s_wb_adr_o (s_adr),
        .s_wb_dat_o (s_dout),
        .s_wb_sel_o (s_sel),
        .s_wb_dat_i (s_dat),
        .s_wb_ack_i (s_ack),
        .s_wb_err_i (s_err)
`ifdef WB_SPLIT_TIMEOUT_EN
        ,
        .tmo_flag_o (tmo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Response monitor: every ack/err must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (m_ack || m_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp ack=%0b err=%0b cyc=%0d",
                         m_ack, m_err, cyc);
            end else begin
                e = q.pop_front();
                chk("resp_ack", 64'(m_ack), 64'(!e.err));
                chk("resp_err", 64'(m_err), 64'(e.err));
                chk("resp_dat", 64'(m_dat), 64'(e.dat));
                chk("resp_cyc", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic push(input bit err, input logic [31:0] dat,
                        input int off);
        exp_t x;
        x.err = err;
        x.dat = dat;
        x.cyc = cyc + off;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        chk("pending", 64'(q.size()), 64'd0);
    endtask

    // Master + slave driver; the slave answers in cycle rcyc (0 = never).
    task automatic xfer(input logic [31:0] adr, input logic we,
                        input logic [31:0] wd, input int rcyc,
                        input logic ra, input logic re,
                        input logic [31:0] rd, input int budget,
                        output int nstb, output bit got);
        int        slot;
        logic [N-1:0] mask;
        bit        done;
        slot = int'(adr[16 +: 5]);
        mask = '0;
        if (slot < N) mask[slot] = 1'b1;
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_we   = we;
        m_adr  = adr;
        m_wdat = wd;
        m_sel  = 4'hF;
        nstb   = 0;
        done   = 1'b0;
        for (int k = 1; k <= budget && !done; k++) begin
            @(posedge clk);
            #1;
            s_ack = '0;
            s_err = '0;
            s_dat = '0;
            if (m_ack || m_err) begin
                done  = 1'b1;
                m_cyc = 1'b0;
                m_stb = 1'b0;
                chk("resp_stb_low", 64'(s_stb), 64'd0);
            end else begin
                chk("stb_mask", 64'(s_stb), 64'(mask));
                if (s_stb != '0) nstb++;
                if (k == 1 && slot < N) begin
                    chk("bcast_adr", 64'(s_adr[slot*AW +: AW]), 64'(adr));
                    chk("bcast_dat", 64'(s_dout[slot*DW +: DW]), 64'(wd));
                    chk("bcast_sel", 64'(s_sel[slot*SW +: SW]), 64'hF);
                    chk("slave_we", 64'(s_we[slot]), 64'(we));
                end
                if (k == rcyc && slot < N) begin
                    s_ack[slot] = ra;
                    s_err[slot] = re;
                    s_dat[slot*DW +: DW] = rd;
                end
            end
        end
        if (!done) begin
            m_cyc = 1'b0;
            m_stb = 1'b0;
            #1;
            chk("abort_stb_low", 64'(s_stb), 64'd0);
        end
        m_we = 1'b0;
        got  = done;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        int n;
        bit g;
        rst    = 1'b1;
        m_cyc  = 1'b0;
        m_stb  = 1'b0;
        m_we   = 1'b0;
        m_adr  = '0;
        m_wdat = '0;
        m_sel  = '0;
        s_dat  = '0;
        s_ack  = '0;
        s_err  = '0;
        #1;
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_err", 64'(m_err), 64'd0);
        chk("rst_dat", 64'(m_dat), 64'd0);
        chk("rst_stb", 64'(s_stb | s_cyc | s_we), 64'd0);
        chk("rst_bus", 64'(|{s_adr, s_dout, s_sel}), 64'd0);
`ifdef WB_SPLIT_TIMEOUT_EN
        chk("rst_tmo", 64'(tmo), 64'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Mapped write, slave 3 acks in cycle 3.
        push(1'b0, 32'h0, 4);
        xfer(32'h0003_0010, 1'b1, 32'h1234_5678, 3, 1'b1, 1'b0, 32'h0,
             20, n, g);
        chk("wr_stb_cycles", 64'(n), 64'd3);
        idle(2);

        // Mapped read, slave 22 answers combinationally in cycle 1.
        push(1'b0, 32'hCAFE_F00D, 2);
        xfer(32'h0016_0000, 1'b0, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_F00D,
             20, n, g);
        chk("rd_stb_cycles", 64'(n), 64'd1);
        idle(2);

        // Unmapped slot 27.
        push(1'b1, 32'h0, 1);
        xfer(32'h001B_0000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 20, n, g);
        chk("unmap_stb_cycles", 64'(n), 64'd0);
        idle(2);

        // Slave error from slot 1 in cycle 2.
        push(1'b1, 32'h0, 3);
        xfer(32'h0001_0004, 1'b0, 32'h0, 2, 1'b0, 1'b1, 32'hDEAD_0001,
             20, n, g);
        chk("serr_stb_cycles", 64'(n), 64'd2);
        idle(2);

        // Slave 5 never responds.
`ifdef WB_SPLIT_TIMEOUT_EN
        push(1'b1, 32'h0, TMO + 1);
        xfer(32'h0005_0000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 40, n, g);
        chk("tmo_stb_cycles", 64'(n), 64'(TMO));
        chk("tmo_got", 64'(g), 64'd1);
        idle(2);
        chk("tmo_flag_set", 64'(tmo), 64'd1);
`else
        xfer(32'h0005_0000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 200, n, g);
        chk("notmo_stb_cycles", 64'(n), 64'd200);
        chk("notmo_got", 64'(g), 64'd0);
        idle(2);
`endif

        // Master abort in cycle 2 of an access to slot 9.
        xfer(32'h0009_0000, 1'b1, 32'h0000_00AA, 0, 1'b0, 1'b0, 32'h0,
             2, n, g);
        chk("abort_got", 64'(g), 64'd0);
        idle(4);

        // Ack and err together from slot 0: ack wins.
        push(1'b0, 32'h0BAD_BEEF, 2);
        xfer(32'h0000_0000, 1'b0, 32'h0, 1, 1'b1, 1'b1, 32'h0BAD_BEEF,
             20, n, g);
        idle(2);

        // Reset asserted mid-ACTIVE.
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_adr = 32'h0009_0000;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_stb", 64'(s_stb), 64'(1 << 9));
`ifdef WB_SPLIT_TIMEOUT_EN
        chk("tmo_flag_sticky", 64'(tmo), 64'd1);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stb", 64'(s_stb | s_cyc | s_we), 64'd0);
        chk("arst_dat", 64'(m_dat), 64'd0);
        chk("arst_bus", 64'(|{s_adr, s_dout, s_sel}), 64'd0);
`ifdef WB_SPLIT_TIMEOUT_EN
        chk("arst_tmo", 64'(tmo), 64'd0);
`endif
        m_cyc = 1'b0;
        m_stb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Normal access after reset.
        push(1'b0, 32'hA5A5_0001, 3);
        xfer(32'h0000_0008, 1'b0, 32'h0, 2, 1'b1, 1'b0, 32'hA5A5_0001,
             20, n, g);
        idle(2);

        // Ack in the final counted cycle beats the watchdog.
        push(1'b0, 32'h0000_55AA, TMO + 1);
        xfer(32'h0005_0000, 1'b0, 32'h0, TMO, 1'b1, 1'b0, 32'h0000_55AA,
             40, n, g);
        chk("late_stb_cycles", 64'(n), 64'(TMO));
        idle(2);
`ifdef WB_SPLIT_TIMEOUT_EN
        chk("late_tmo_clear", 64'(tmo), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
